apb_adv_timer_pwm_capture: RTL and testbench
============================================

APB_ADV_TIMER_PWM_CAPTURE -- requirements
Module: apb_adv_timer_pwm_capture

Interface
REQ-001 Parameter CNT_W, default 32: width of the cycle counter and of the result fields.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_ni  input  1  reset, synchronous, active-low.
REQ-004 en_i  input  1  capture enable; low forces IDLE.
REQ-005 sel_i  input  2  selects which bit of ch_i is measured; sampled only on the IDLE->WAIT_RISE transition.
REQ-006 ch_i  input  4  timer channel PWM outputs (one timer's ch_N_o bus); synchronous to clk_i.
REQ-007 meas_ready_i  input  1  consumer accepts the result when high together with meas_valid_o.
REQ-008 meas_valid_o  output  1  result valid.
REQ-009 high_o  output  CNT_W  high-phase length in clk_i cycles.
REQ-010 period_o  output  CNT_W  rise-to-rise period in clk_i cycles.
REQ-011 overflow_o  output  1  sticky: counter saturated during a measurement.
REQ-012 dropped_o  output  1  sticky: a completed result was discarded because the output was still occupied.
REQ-013 busy_o  output  1  high in any state other than IDLE.

Function
REQ-014 The block SHALL register the selected bit into s_q each cycle and define rise = bit & ~s_q, fall = ~bit & s_q, using the current bit and the previous cycle's s_q.
REQ-015 States SHALL be IDLE, WAIT_RISE, MEAS_HIGH and MEAS_LOW, with the following transitions:
- IDLE->WAIT_RISE when en_i=1; sel_i latched and s_q loaded with the selected bit in the same cycle, so a level already high does not count as a rise.
- WAIT_RISE->MEAS_HIGH on rise; counter loaded with 1.
- MEAS_HIGH->MEAS_LOW on fall; high length latched from the counter value.
- MEAS_LOW->MEAS_HIGH on rise; result completed and counter reloaded with 1, so measurement is back-to-back continuous.
REQ-016 In MEAS_HIGH and MEAS_LOW, on cycles with no edge, the counter SHALL increment by 1.
REQ-017 Result values SHALL be: high_o = number of cycles the bit was 1; period_o = number of cycles from one rise to the next. Example: 3 high + 5 low gives high_o=3, period_o=8.
REQ-018 A completed result SHALL load the output registers and assert meas_valid_o on the cycle after the terminating rise.
REQ-019 meas_valid_o SHALL stay high with high_o/period_o stable until the cycle after meas_valid_o & meas_ready_i.
REQ-020 If a result completes while meas_valid_o=1 and meas_ready_i=0, the new result SHALL be discarded, dropped_o set, and the held result kept.
REQ-021 If handshake and completion coincide in the same cycle, the new result SHALL be loaded, meas_valid_o stays high, and dropped_o is not set.
REQ-022 If the counter reaches 2^CNT_W-1 without the required edge, the block SHALL set overflow_o, produce no result, and go to WAIT_RISE.
REQ-023 en_i=0 SHALL move any state to IDLE on the next cycle and discard the measurement in progress; the pending output result and its handshake SHALL remain unaffected.
REQ-024 overflow_o and dropped_o SHALL clear only on reset or on the IDLE->WAIT_RISE transition.
REQ-025 Changes to sel_i while busy_o=1 SHALL have no effect.
REQ-026 A 1-cycle-high or 1-cycle-low pulse SHALL be measured correctly (high_o=1, or period_o-high_o=1).

Reset
REQ-027 With rst_ni=0 at a clock edge, the block SHALL enter IDLE and clear the following: meas_valid_o, high_o, period_o, overflow_o, dropped_o, busy_o, the counter, s_q and the latched sel.
REQ-028 Reset asserted mid-measurement or with a pending result SHALL discard both; no result SHALL appear after reset release until a full rise-to-rise cycle is observed.

Verification
REQ-029 sel_i=2, ch_i[2] PWM 3 high / 5 low, meas_ready_i=1 -> every 8 cycles meas_valid_o pulses with high_o=3, period_o=8; the first result follows the second rise.
REQ-030 ch_i[0] already high at enable, then low 2 cycles, high 4, low 4 -> first result high_o=4, period_o=8; the initial high level is not counted as a rise.
REQ-031 meas_ready_i held 0 across two completed periods -> the first result is held stable, dropped_o=1; after ready, the next new result is high_o/period_o of the current waveform.
REQ-032 CNT_W=4, bit held high 20 cycles -> overflow_o=1 after 15 counts, state WAIT_RISE, no meas_valid_o.
REQ-033 en_i dropped mid-MEAS_LOW, then re-enabled -> busy_o=0 the next cycle, overflow_o/dropped_o cleared on re-enable, and the first result requires two fresh rises.
REQ-034 rst_ni=0 for 1 cycle while meas_valid_o=1 -> all outputs 0 on the following cycle; 1-high/1-low toggling after release -> high_o=1, period_o=2.

Source files
------------

// File: rtl/apb_adv_timer_pwm_capture_if.sv
// Result handshake between the PWM capture block (master) and its consumer (slave).
// Signal names match the original flat ports of the capture block.
interface apb_adv_timer_pwm_capture_if #(
    parameter int unsigned CNT_W = 32
) ();
    logic             meas_valid_o;
    logic             meas_ready_i;
    logic [CNT_W-1:0] high_o;
    logic [CNT_W-1:0] period_o;

    modport master (
        output meas_valid_o,
        output high_o,
        output period_o,
        input  meas_ready_i
    );

    modport slave (
        input  meas_valid_o,
        input  high_o,
        input  period_o,
        output meas_ready_i
    );
endinterface

// File: rtl/apb_adv_timer_pwm_capture.sv
// Measures high-phase length and rise-to-rise period of one selected timer channel,
// continuously, delivering results over a valid/ready handshake.
module apb_adv_timer_pwm_capture #(
    parameter int unsigned CNT_W = 32
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               en_i,
    input  logic [1:0]                         sel_i,
    input  logic [3:0]                         ch_i,
    apb_adv_timer_pwm_capture_if.master        meas,
    output logic                               overflow_o,
    output logic                               dropped_o,
    output logic                               busy_o
);
    typedef enum logic [1:0] {
        IDLE,
        WAIT_RISE,
        MEAS_HIGH,
        MEAS_LOW
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic             s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hlat_q, hlat_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             drop_q, drop_d;

    logic bit_w, rise, fall, complete, hs;

    always_comb begin
        bit_w    = ch_i[sel_q];
        rise     = bit_w & ~s_q;
        fall     = ~bit_w & s_q;
        hs       = valid_q & meas.meas_ready_i;
        complete = 1'b0;

        state_d  = state_q;
        sel_d    = sel_q;
        s_d      = bit_w;
        cnt_d    = cnt_q;
        hlat_d   = hlat_q;
        high_d   = high_q;
        period_d = period_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;

        if (!en_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    // Preload s_q so a level that is already high is not seen as a rise.
                    state_d = WAIT_RISE;
                    sel_d   = sel_i;
                    s_d     = ch_i[sel_i];
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    drop_d  = 1'b0;
                end
                WAIT_RISE: begin
                    if (rise) begin
                        state_d = MEAS_HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
                MEAS_HIGH: begin
                    // The fall cycle still counts towards the period, so it increments too.
                    if (cnt_q == CNT_MAX) begin
                        ovf_d   = 1'b1;
                        state_d = WAIT_RISE;
                    end else if (fall) begin
                        hlat_d  = cnt_q;
                        cnt_d   = cnt_q + CNT_ONE;
                        state_d = MEAS_LOW;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                MEAS_LOW: begin
                    if (rise) begin
                        complete = 1'b1;
                        cnt_d    = CNT_ONE;
                        state_d  = MEAS_HIGH;
                    end else if (cnt_q == CNT_MAX) begin
                        ovf_d   = 1'b1;
                        state_d = WAIT_RISE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            endcase
        end

        if (complete) begin
            if (!valid_q || hs) begin
                valid_d  = 1'b1;
                high_d   = hlat_q;
                period_d = cnt_q;
            end else begin
                drop_d = 1'b1;
            end
        end else if (hs) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            s_q      <= 1'b0;
            cnt_q    <= '0;
            hlat_q   <= '0;
            high_q   <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            s_q      <= s_d;
            cnt_q    <= cnt_d;
            hlat_q   <= hlat_d;
            high_q   <= high_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    assign meas.meas_valid_o = valid_q;
    assign meas.high_o       = high_q;
    assign meas.period_o     = period_q;
    assign overflow_o        = ovf_q;
    assign dropped_o         = drop_q;
    assign busy_o            = (state_q != IDLE);
endmodule

// File: tb/tb_apb_adv_timer_pwm_capture.sv
// Directed bench for apb_adv_timer_pwm_capture: PWM pattern table plus hand-written
// sequences for latency, pre-high level, drop, disable, reset and overflow.
module tb_apb_adv_timer_pwm_capture;
    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] sel;
    logic [3:0] ch;
    logic       ovf, drop, busy;

    logic       en4;
    logic [3:0] ch4;
    logic       ovf4, drop4, busy4;

    int n_vec;
    int n_err;
    int vcnt;
    int vcnt4;

    typedef struct packed {
        logic [31:0] h;
        logic [31:0] p;
    } res_t;
    res_t acc[$];

    typedef struct {
        logic [1:0]  sel;
        int unsigned hi;
        int unsigned lo;
        logic [31:0] exp_h;
        logic [31:0] exp_p;
    } vec_t;
    vec_t tbl[5];

    apb_adv_timer_pwm_capture_if #(.CNT_W(32)) mif ();
    apb_adv_timer_pwm_capture_if #(.CNT_W(4))  mif4 ();

    apb_adv_timer_pwm_capture #(.CNT_W(32)) u_dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en),
        .sel_i      (sel),
        .ch_i       (ch),
        .meas       (mif),
        .overflow_o (ovf),
        .dropped_o  (drop),
        .busy_o     (busy)
    );

    apb_adv_timer_pwm_capture #(.CNT_W(4)) u_dut4 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en4),
        .sel_i      (2'd0),
        .ch_i       (ch4),
        .meas       (mif4),
        .overflow_o (ovf4),
        .dropped_o  (drop4),
        .busy_o     (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change #1 after a rising edge; outputs are read at the same point.
    task automatic step(input logic [3:0] c);
        ch = c;
        if (mif.meas_valid_o && mif.meas_ready_i)
            acc.push_back({mif.high_o, mif.period_o});
        if (mif.meas_valid_o) vcnt++;
        if (mif4.meas_valid_o) vcnt4++;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] pat(input logic [1:0] s, input logic b);
        logic [3:0] r;
        r    = {4{~b}};
        r[s] = b;
        return r;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        en4   = 1'b0;
        ch4   = 4'h0;
        step(4'h0);
        step(4'h0);
        rst_n = 1'b1;
        acc.delete();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        vcnt  = 0;
        vcnt4 = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        sel   = 2'd0;
        ch    = 4'h0;
        en4   = 1'b0;
        ch4   = 4'h0;
        mif.meas_ready_i  = 1'b0;
        mif4.meas_ready_i = 1'b1;

        tbl[0] = '{sel: 2'd2, hi: 3, lo: 5, exp_h: 32'd3, exp_p: 32'd8};
        tbl[1] = '{sel: 2'd0, hi: 1, lo: 1, exp_h: 32'd1, exp_p: 32'd2};
        tbl[2] = '{sel: 2'd1, hi: 1, lo: 4, exp_h: 32'd1, exp_p: 32'd5};
        tbl[3] = '{sel: 2'd3, hi: 6, lo: 1, exp_h: 32'd6, exp_p: 32'd7};
        tbl[4] = '{sel: 2'd2, hi: 2, lo: 2, exp_h: 32'd2, exp_p: 32'd4};

        // Reset values
        do_reset();
        chk("rst_valid",  {31'd0, mif.meas_valid_o}, 32'd0);
        chk("rst_high",   mif.high_o, 32'd0);
        chk("rst_period", mif.period_o, 32'd0);
        chk("rst_ovf",    {31'd0, ovf}, 32'd0);
        chk("rst_drop",   {31'd0, drop}, 32'd0);
        chk("rst_busy",   {31'd0, busy}, 32'd0);

        // Pattern table: four periods give three results (first rise only arms)
        for (int i = 0; i < 5; i++) begin
            do_reset();
            sel = tbl[i].sel;
            mif.meas_ready_i = 1'b1;
            en = 1'b1;
            step(pat(sel, 1'b0));
            sel = ~tbl[i].sel;
            acc.delete();
            for (int p = 0; p < 4; p++) begin
                for (int unsigned k = 0; k < tbl[i].hi; k++) step(pat(tbl[i].sel, 1'b1));
                for (int unsigned k = 0; k < tbl[i].lo; k++) step(pat(tbl[i].sel, 1'b0));
            end
            step(pat(tbl[i].sel, 1'b0));
            step(pat(tbl[i].sel, 1'b0));
            chk($sformatf("tbl%0d_count", i), acc.size(), 32'd3);
            for (int k = 0; k < 3; k++) begin
                if (k < acc.size()) begin
                    chk($sformatf("tbl%0d_high%0d", i, k), acc[k].h, tbl[i].exp_h);
                    chk($sformatf("tbl%0d_period%0d", i, k), acc[k].p, tbl[i].exp_p);
                end
            end
        end

        // First result appears the cycle after the second rise
        do_reset();
        sel = 2'd2;
        mif.meas_ready_i = 1'b1;
        en = 1'b1;
        step(4'h0);
        vcnt = 0;
        for (int k = 0; k < 3; k++) step(4'b0100);
        for (int k = 0; k < 5; k++) step(4'b0000);
        chk("lat_no_early", vcnt, 32'd0);
        step(4'b0100);
        chk("lat_valid",  {31'd0, mif.meas_valid_o}, 32'd1);
        chk("lat_high",   mif.high_o, 32'd3);
        chk("lat_period", mif.period_o, 32'd8);

        // Level already high at enable is not a rise
        do_reset();
        sel = 2'd0;
        mif.meas_ready_i = 1'b1;
        en = 1'b1;
        step(4'b0001);
        vcnt = 0;
        for (int k = 0; k < 2; k++) step(4'b0000);
        for (int k = 0; k < 4; k++) step(4'b0001);
        for (int k = 0; k < 4; k++) step(4'b0000);
        chk("prehi_no_early", vcnt, 32'd0);
        step(4'b0001);
        chk("prehi_valid",  {31'd0, mif.meas_valid_o}, 32'd1);
        chk("prehi_high",   mif.high_o, 32'd4);
        chk("prehi_period", mif.period_o, 32'd8);

        // Consumer stalled across completions: hold first result, flag drop
        do_reset();
        sel = 2'd1;
        mif.meas_ready_i = 1'b0;
        en = 1'b1;
        step(4'h0);
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 2; k++) step(4'b0010);
            for (int k = 0; k < 3; k++) step(4'b0000);
        end
        step(4'b0010);
        chk("drop_valid",  {31'd0, mif.meas_valid_o}, 32'd1);
        chk("drop_high",   mif.high_o, 32'd2);
        chk("drop_period", mif.period_o, 32'd5);
        chk("drop_flag",   {31'd0, drop}, 32'd1);
        acc.delete();
        mif.meas_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) step(4'b0010);
        step(4'b0000);
        step(4'b0010);
        step(4'b0010);
        chk("drop_acc_count", acc.size(), 32'd2);
        if (acc.size() == 2) begin
            chk("drop_acc0_high",   acc[0].h, 32'd2);
            chk("drop_acc0_period", acc[0].p, 32'd5);
            chk("drop_acc1_high",   acc[1].h, 32'd4);
            chk("drop_acc1_period", acc[1].p, 32'd5);
        end
        chk("drop_sticky", {31'd0, drop}, 32'd1);

        // Disable mid-MEAS_LOW, then re-enable
        step(4'b0000);
        en = 1'b0;
        step(4'b0000);
        chk("dis_busy",  {31'd0, busy}, 32'd0);
        chk("dis_drop",  {31'd0, drop}, 32'd1);
        en = 1'b1;
        step(4'b0000);
        chk("reen_busy", {31'd0, busy}, 32'd1);
        chk("reen_drop", {31'd0, drop}, 32'd0);
        chk("reen_ovf",  {31'd0, ovf}, 32'd0);
        vcnt = 0;
        for (int k = 0; k < 2; k++) step(4'b0010);
        for (int k = 0; k < 3; k++) step(4'b0000);
        chk("reen_no_early", vcnt, 32'd0);
        step(4'b0010);
        chk("reen_valid",  {31'd0, mif.meas_valid_o}, 32'd1);
        chk("reen_high",   mif.high_o, 32'd2);
        chk("reen_period", mif.period_o, 32'd5);

        // Reset with a pending result, then 1-high/1-low toggling
        do_reset();
        sel = 2'd3;
        mif.meas_ready_i = 1'b0;
        en = 1'b1;
        step(4'b0000);
        step(4'b1000);
        step(4'b0000);
        step(4'b1000);
        chk("pend_valid",  {31'd0, mif.meas_valid_o}, 32'd1);
        chk("pend_high",   mif.high_o, 32'd1);
        chk("pend_period", mif.period_o, 32'd2);
        rst_n = 1'b0;
        step(4'b0000);
        rst_n = 1'b1;
        chk("mrst_valid",  {31'd0, mif.meas_valid_o}, 32'd0);
        chk("mrst_high",   mif.high_o, 32'd0);
        chk("mrst_period", mif.period_o, 32'd0);
        chk("mrst_busy",   {31'd0, busy}, 32'd0);
        chk("mrst_drop",   {31'd0, drop}, 32'd0);
        chk("mrst_ovf",    {31'd0, ovf}, 32'd0);
        mif.meas_ready_i = 1'b1;
        vcnt = 0;
        step(4'b0000);
        step(4'b1000);
        step(4'b0000);
        chk("mrst_no_early", vcnt, 32'd0);
        step(4'b1000);
        chk("tog_valid",  {31'd0, mif.meas_valid_o}, 32'd1);
        chk("tog_high",   mif.high_o, 32'd1);
        chk("tog_period", mif.period_o, 32'd2);

        // 4-bit counter saturates while the bit stays high
        do_reset();
        en4 = 1'b1;
        step(4'h0);
        vcnt4 = 0;
        ch4 = 4'b0001;
        for (int k = 0; k < 10; k++) step(4'h0);
        chk("ovf_early", {31'd0, ovf4}, 32'd0);
        for (int k = 0; k < 10; k++) step(4'h0);
        chk("ovf_set",      {31'd0, ovf4}, 32'd1);
        chk("ovf_busy",     {31'd0, busy4}, 32'd1);
        chk("ovf_no_valid", vcnt4, 32'd0);
        chk("ovf_no_drop",  {31'd0, drop4}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
